// File: rtl/mem_loader_pkg.sv
// Shared types and helpers for the flash-to-RAM image loader.
package mem_loader_pkg;

  localparam int unsigned CHECKSUM_WIDTH = 32;
  // Widest word byte_swap can handle; loader words must not exceed this.
  localparam int unsigned MAX_DATA_WIDTH = 256;
  localparam int unsigned SWAP_IDX_WIDTH = $clog2(MAX_DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_DATA,
    S_GAP,
    S_DONE,
    S_ERROR
  } loader_state_t;

  // Reverses the order of the lowest num_bytes bytes; upper bytes of the result are zero.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_swap(
    input logic [MAX_DATA_WIDTH-1:0] data,
    input int unsigned               num_bytes
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    logic [SWAP_IDX_WIDTH-1:0] lo;
    logic [SWAP_IDX_WIDTH-1:0] hi;
    res = '0;
    for (int unsigned i = 0; i < MAX_DATA_WIDTH / 8; i++) begin
      if (i < num_bytes) begin
        lo = SWAP_IDX_WIDTH'(8 * i);
        hi = SWAP_IDX_WIDTH'(8 * (num_bytes - 1 - i));
        res[lo +: 8] = data[hi +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_image_loader.sv
// Copies a NUM_WORDS image from an Avalon-MM flash read port into on-chip RAM, one read in
// flight at a time, with optional byte swap, inter-word gap, read timeout and running checksum.
module mem_image_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned RAM_ADDR_WIDTH   = 14,
  parameter int unsigned FLASH_ADDR_WIDTH = 17,
  parameter int unsigned FLASH_BASE       = 0,
  parameter int unsigned NUM_WORDS        = 2 ** RAM_ADDR_WIDTH,
  parameter int unsigned GAP_CYCLES       = 4,
  parameter int unsigned BYTE_SWAP        = 1,
  parameter int unsigned TIMEOUT_CYCLES   = 255,
  parameter int unsigned AUTO_START       = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  output logic [FLASH_ADDR_WIDTH-1:0] flash_addr,
  output logic                        flash_read,
  input  logic                        flash_waitrequest,
  input  logic [DATA_WIDTH-1:0]       flash_readdata,
  input  logic                        flash_readdatavalid,
  output logic                        ram_we,
  output logic [RAM_ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]       ram_data,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [CHECKSUM_WIDTH-1:0]   checksum
);

  // One timer serves both the gap and the read timeout; they are never active together.
  localparam int unsigned TimerMax   = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned TimerWidth = (TimerMax > 1) ? $clog2(TimerMax) : 1;

  localparam logic [TimerWidth-1:0]       TimeoutLast = TimerWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerWidth-1:0]       GapLast     = TimerWidth'(GAP_CYCLES - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0]   LastWord    = RAM_ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [FLASH_ADDR_WIDTH-1:0] BaseAddr    = FLASH_ADDR_WIDTH'(FLASH_BASE);

  loader_state_t               state_q;
  logic                        auto_q;
  logic [RAM_ADDR_WIDTH-1:0]   counter_q;
  logic [TimerWidth-1:0]       timer_q;
  logic [DATA_WIDTH-1:0]       wr_word;
  logic [FLASH_ADDR_WIDTH-1:0] next_flash_addr;

  always_comb begin
    wr_word = flash_readdata;
    if (BYTE_SWAP != 0) begin
      wr_word = DATA_WIDTH'(byte_swap(MAX_DATA_WIDTH'(flash_readdata), DATA_WIDTH / 8));
    end
  end

  assign next_flash_addr = BaseAddr + FLASH_ADDR_WIDTH'(counter_q) + FLASH_ADDR_WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      auto_q     <= (AUTO_START != 0);
      counter_q  <= '0;
      timer_q    <= '0;
      flash_read <= 1'b0;
      flash_addr <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      checksum   <= '0;
    end else begin
      ram_we <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start || (state_q == S_IDLE && auto_q)) begin
            state_q    <= S_READ;
            auto_q     <= 1'b0;
            counter_q  <= '0;
            checksum   <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b1;
            flash_read <= 1'b1;
            flash_addr <= BaseAddr;
          end
        end
        S_READ: begin
          if (!flash_waitrequest) begin
            state_q    <= S_WAIT_DATA;
            flash_read <= 1'b0;
            timer_q    <= '0;
          end
        end
        S_WAIT_DATA: begin
          if (flash_readdatavalid) begin
            ram_we   <= 1'b1;
            ram_addr <= counter_q;
            ram_data <= wr_word;
            checksum <= checksum + CHECKSUM_WIDTH'(wr_word);
            // Terminal check before increment keeps the counter from wrapping on a full image.
            if (counter_q == LastWord) begin
              state_q <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              counter_q  <= counter_q + RAM_ADDR_WIDTH'(1);
              flash_addr <= next_flash_addr;
              timer_q    <= '0;
              if (GAP_CYCLES == 0) begin
                state_q    <= S_READ;
                flash_read <= 1'b1;
              end else begin
                state_q <= S_GAP;
              end
            end
          end else if (timer_q == TimeoutLast) begin
            state_q <= S_ERROR;
            busy    <= 1'b0;
            error   <= 1'b1;
          end else begin
            timer_q <= timer_q + TimerWidth'(1);
          end
        end
        S_GAP: begin
          if (timer_q == GapLast) begin
            state_q    <= S_READ;
            flash_read <= 1'b1;
          end else begin
            timer_q <= timer_q + TimerWidth'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_image_loader.sv
// Directed bench: instance A (4 words, gap 2, swap, base 16) and instance B (8 words, gap 0).
module tb_mem_image_loader;

  localparam int unsigned AAW   = 4;
  localparam int unsigned AFW   = 8;
  localparam int unsigned ABASE = 16;
  localparam int unsigned BAW   = 3;
  localparam int unsigned BFW   = 4;

  localparam logic [31:0] ACsum    = 32'h06CC8844;
  localparam logic [31:0] APartial = 32'h01664422;
  localparam logic [31:0] BCsum    = 32'h2D28001C;

  logic [31:0] a_exp [4] = '{32'h00332211, 32'h01332211, 32'h02332211, 32'h03332211};

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic a_start = 1'b0;
  logic b_start = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A signals
  logic [AFW-1:0] a_faddr;
  logic           a_fread;
  logic           a_wait;
  logic [31:0]    a_rdata = '0;
  logic           a_valid = 1'b0;
  logic           a_we;
  logic [AAW-1:0] a_waddr;
  logic [31:0]    a_wdata;
  logic           a_busy, a_done, a_err;
  logic [31:0]    a_csum;

  // Instance B signals
  logic [BFW-1:0] b_faddr;
  logic           b_fread;
  logic           b_wait;
  logic [31:0]    b_rdata = '0;
  logic           b_valid = 1'b0;
  logic           b_we;
  logic [BAW-1:0] b_waddr;
  logic [31:0]    b_wdata;
  logic           b_busy, b_done, b_err;
  logic [31:0]    b_csum;

  mem_image_loader #(
    .DATA_WIDTH(32), .RAM_ADDR_WIDTH(AAW), .FLASH_ADDR_WIDTH(AFW), .FLASH_BASE(ABASE),
    .NUM_WORDS(4), .GAP_CYCLES(2), .BYTE_SWAP(1), .TIMEOUT_CYCLES(8), .AUTO_START(1)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start),
    .flash_addr(a_faddr), .flash_read(a_fread), .flash_waitrequest(a_wait),
    .flash_readdata(a_rdata), .flash_readdatavalid(a_valid),
    .ram_we(a_we), .ram_addr(a_waddr), .ram_data(a_wdata),
    .busy(a_busy), .done(a_done), .error(a_err), .checksum(a_csum)
  );

  mem_image_loader #(
    .DATA_WIDTH(32), .RAM_ADDR_WIDTH(BAW), .FLASH_ADDR_WIDTH(BFW), .FLASH_BASE(0),
    .NUM_WORDS(8), .GAP_CYCLES(0), .BYTE_SWAP(0), .TIMEOUT_CYCLES(8), .AUTO_START(1)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start),
    .flash_addr(b_faddr), .flash_read(b_fread), .flash_waitrequest(b_wait),
    .flash_readdata(b_rdata), .flash_readdatavalid(b_valid),
    .ram_we(b_we), .ram_addr(b_waddr), .ram_data(b_wdata),
    .busy(b_busy), .done(b_done), .error(b_err), .checksum(b_csum)
  );

  // Flash model A: word k holds 0x11223300+k; optional stall on one word, optional dropped word.
  int stall_word   = -1;
  int stall_cycles = 0;
  int drop_word    = -1;
  int a_stall_cnt  = 0;
  int a_word;
  assign a_word = int'(a_faddr) - int'(ABASE);
  assign a_wait = a_fread && (a_word == stall_word) && (a_stall_cnt < stall_cycles);

  always @(posedge clk) begin
    a_valid <= 1'b0;
    if (!a_fread) a_stall_cnt <= 0;
    else if (a_wait) a_stall_cnt <= a_stall_cnt + 1;
    if (a_fread && !a_wait && a_word != drop_word) begin
      a_valid <= 1'b1;
      a_rdata <= 32'h11223300 + 32'(a_word);
    end
  end

  // Flash model B: never stalls, word k holds 0xA5A50000+k.
  assign b_wait = 1'b0;
  always @(posedge clk) begin
    b_valid <= b_fread;
    if (b_fread) b_rdata <= 32'hA5A50000 + 32'(b_faddr);
  end

  // Monitors
  int          a_wr_cyc[$], a_wr_addr[$], a_acc_cyc[$], a_acc_addr[$], a_acc_len[$], a_val_cyc[$];
  logic [31:0] a_wr_data[$];
  bit          a_acc_stable[$];
  int          b_wr_cyc[$], b_wr_addr[$], b_acc_cyc[$];
  logic [31:0] b_wr_data[$];
  int a_run_start = 0;
  int a_run_addr  = 0;
  bit a_run_ok    = 1'b0;
  bit a_prev_read = 1'b0;
  bit a_prev_err  = 1'b0;
  int a_err_cyc   = 0;

  always @(negedge clk) begin
    if (a_we) begin
      a_wr_cyc.push_back(cyc);
      a_wr_addr.push_back(int'(a_waddr));
      a_wr_data.push_back(a_wdata);
    end
    if (a_valid) a_val_cyc.push_back(cyc);
    if (a_fread && !a_wait) begin
      a_acc_cyc.push_back(cyc);
      a_acc_addr.push_back(int'(a_faddr));
      a_acc_len.push_back(a_prev_read ? cyc - a_run_start + 1 : 1);
      a_acc_stable.push_back(!a_prev_read || (a_run_ok && int'(a_faddr) == a_run_addr));
    end
    if (a_fread && !a_prev_read) begin
      a_run_start <= cyc;
      a_run_addr  <= int'(a_faddr);
      a_run_ok    <= 1'b1;
    end else if (a_fread && int'(a_faddr) != a_run_addr) begin
      a_run_ok <= 1'b0;
    end
    a_prev_read <= a_fread;
    if (a_err && !a_prev_err) a_err_cyc <= cyc;
    a_prev_err <= a_err;
    if (b_we) begin
      b_wr_cyc.push_back(cyc);
      b_wr_addr.push_back(int'(b_waddr));
      b_wr_data.push_back(b_wdata);
    end
    if (b_fread && !b_wait) b_acc_cyc.push_back(cyc);
  end

  task automatic pulse_a_start();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_a_done(input string name);
    int t = 0;
    while (a_done !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (a_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done=%b, required 1 within 400 cycles", name, a_done);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_fread, a_we, a_busy, a_done, a_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000", {a_fread, a_we, a_busy, a_done, a_err});
    end
    checks++;
    if (a_csum !== 32'h0) begin
      errors++;
      $display("FAIL reset_checksum: got %h, required 0", a_csum);
    end
    checks++;
    if (a_faddr !== '0 || a_waddr !== '0 || a_wdata !== '0) begin
      errors++;
      $display("FAIL reset_addr_data: got %h/%h/%h, required 0", a_faddr, a_waddr, a_wdata);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b1 || a_fread !== 1'b1 || a_faddr !== 8'(ABASE)) begin
      errors++;
      $display("FAIL auto_start: busy=%b read=%b addr=%h, required 1 1 %h",
               a_busy, a_fread, a_faddr, 8'(ABASE));
    end
  endtask

  task automatic test_basic();
    wait_a_done("basic");
    checks++;
    if (a_wr_cyc.size() != 4) begin
      errors++;
      $display("FAIL basic_write_count: got %0d, required 4", a_wr_cyc.size());
    end
    for (int k = 0; k < 4 && k < a_wr_cyc.size(); k++) begin
      checks++;
      if (a_wr_addr[k] != k || a_wr_data[k] !== a_exp[k]) begin
        errors++;
        $display("FAIL basic_write[%0d]: got addr %0d data %h, required addr %0d data %h",
                 k, a_wr_addr[k], a_wr_data[k], k, a_exp[k]);
      end
      checks++;
      if (k < a_val_cyc.size() && a_wr_cyc[k] - a_val_cyc[k] != 1) begin
        errors++;
        $display("FAIL basic_latency[%0d]: got %0d cycles, required 1", k,
                 a_wr_cyc[k] - a_val_cyc[k]);
      end
      checks++;
      if (k < a_acc_addr.size() && a_acc_addr[k] != int'(ABASE) + k) begin
        errors++;
        $display("FAIL basic_flash_addr[%0d]: got %0d, required %0d", k, a_acc_addr[k],
                 int'(ABASE) + k);
      end
    end
    for (int k = 0; k < 3 && k + 1 < a_acc_cyc.size() && k < a_wr_cyc.size(); k++) begin
      checks++;
      if (a_acc_cyc[k + 1] - a_wr_cyc[k] != 2) begin
        errors++;
        $display("FAIL basic_gap[%0d]: got %0d cycles, required 2", k,
                 a_acc_cyc[k + 1] - a_wr_cyc[k]);
      end
    end
    checks++;
    if (a_csum !== ACsum || a_busy !== 1'b0 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_final: csum=%h busy=%b err=%b, required %h 0 0",
               a_csum, a_busy, a_err, ACsum);
    end
  endtask

  task automatic test_waitrequest();
    int wb = a_wr_cyc.size();
    int ab = a_acc_cyc.size();
    stall_word   = 1;
    stall_cycles = 5;
    pulse_a_start();
    wait_a_done("waitreq");
    stall_word = -1;
    checks++;
    if (a_acc_cyc.size() - ab != 4) begin
      errors++;
      $display("FAIL waitreq_reads: got %0d, required 4", a_acc_cyc.size() - ab);
    end else begin
      checks++;
      if (a_acc_len[ab + 1] != 6 || !a_acc_stable[ab + 1] || a_acc_addr[ab + 1] != 17) begin
        errors++;
        $display("FAIL waitreq_hold: len=%0d stable=%0d addr=%0d, required 6 1 17",
                 a_acc_len[ab + 1], a_acc_stable[ab + 1], a_acc_addr[ab + 1]);
      end
    end
    checks++;
    if (a_wr_cyc.size() - wb != 4) begin
      errors++;
      $display("FAIL waitreq_writes: got %0d, required 4", a_wr_cyc.size() - wb);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (a_wr_data[wb + k] !== a_exp[k]) begin
          errors++;
          $display("FAIL waitreq_data[%0d]: got %h, required %h", k, a_wr_data[wb + k], a_exp[k]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int wb = a_wr_cyc.size();
    int ab = a_acc_cyc.size();
    int t  = 0;
    drop_word = 2;
    pulse_a_start();
    while (a_err !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    drop_word = -1;
    checks++;
    if (a_err !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flags: err=%b busy=%b done=%b, required 1 0 0", a_err, a_busy, a_done);
    end
    checks++;
    if (a_wr_cyc.size() - wb != 2 || a_csum !== APartial) begin
      errors++;
      $display("FAIL timeout_partial: writes=%0d csum=%h, required 2 %h",
               a_wr_cyc.size() - wb, a_csum, APartial);
    end
    checks++;
    if (a_acc_cyc.size() - ab != 3 || a_err_cyc - a_acc_cyc[a_acc_cyc.size() - 1] != 9) begin
      errors++;
      $display("FAIL timeout_timing: reads=%0d, required 3; error %0d cycles after accept, required 9",
               a_acc_cyc.size() - ab, a_err_cyc - a_acc_cyc[a_acc_cyc.size() - 1]);
    end
    wb = a_wr_cyc.size();
    pulse_a_start();
    checks++;
    if (a_err !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_restart: err=%b busy=%b, required 0 1", a_err, a_busy);
    end
    wait_a_done("timeout_reload");
    checks++;
    if (a_wr_cyc.size() - wb != 4 || a_csum !== ACsum || a_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_reload: writes=%0d csum=%h err=%b, required 4 %h 0",
               a_wr_cyc.size() - wb, a_csum, a_err, ACsum);
    end
  endtask

  task automatic test_back_to_back();
    int wb = a_wr_cyc.size();
    int ab = a_acc_cyc.size();
    pulse_a_start();
    repeat (6) @(negedge clk);
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: got %b, required 1", a_busy);
    end
    pulse_a_start();
    wait_a_done("b2b_first");
    checks++;
    if (a_wr_cyc.size() - wb != 4 || a_acc_cyc.size() - ab != 4) begin
      errors++;
      $display("FAIL b2b_ignored_start: writes=%0d reads=%0d, required 4 4",
               a_wr_cyc.size() - wb, a_acc_cyc.size() - ab);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (a_wr_addr[wb + k] != k || a_wr_data[wb + k] !== a_exp[k]) begin
          errors++;
          $display("FAIL b2b_write[%0d]: got addr %0d data %h, required addr %0d data %h",
                   k, a_wr_addr[wb + k], a_wr_data[wb + k], k, a_exp[k]);
        end
      end
    end
    checks++;
    if (a_csum !== ACsum) begin
      errors++;
      $display("FAIL b2b_csum_first: got %h, required %h", a_csum, ACsum);
    end
    wb = a_wr_cyc.size();
    pulse_a_start();
    wait_a_done("b2b_second");
    checks++;
    if (a_wr_cyc.size() - wb != 4 || a_csum !== ACsum) begin
      errors++;
      $display("FAIL b2b_second: writes=%0d csum=%h, required 4 %h",
               a_wr_cyc.size() - wb, a_csum, ACsum);
    end
  endtask

  task automatic test_gap0();
    checks++;
    if (b_wr_cyc.size() != 8) begin
      errors++;
      $display("FAIL gap0_write_count: got %0d, required 8", b_wr_cyc.size());
    end
    for (int k = 0; k < 8 && k < b_wr_cyc.size(); k++) begin
      checks++;
      if (b_wr_addr[k] != k || b_wr_data[k] !== 32'hA5A50000 + 32'(k)) begin
        errors++;
        $display("FAIL gap0_write[%0d]: got addr %0d data %h, required addr %0d data %h",
                 k, b_wr_addr[k], b_wr_data[k], k, 32'hA5A50000 + 32'(k));
      end
    end
    for (int k = 0; k < 7 && k + 1 < b_acc_cyc.size() && k < b_wr_cyc.size(); k++) begin
      checks++;
      if (b_acc_cyc[k + 1] != b_wr_cyc[k]) begin
        errors++;
        $display("FAIL gap0_back_to_back[%0d]: read at %0d, required %0d", k,
                 b_acc_cyc[k + 1], b_wr_cyc[k]);
      end
    end
    checks++;
    if (b_csum !== BCsum || b_done !== 1'b1 || b_busy !== 1'b0 || b_err !== 1'b0) begin
      errors++;
      $display("FAIL gap0_final: csum=%h done=%b busy=%b err=%b, required %h 1 0 0",
               b_csum, b_done, b_busy, b_err, BCsum);
    end
  endtask

  task automatic test_reset_midload();
    int wb = a_wr_cyc.size();
    int t  = 0;
    pulse_a_start();
    while (a_wr_cyc.size() - wb < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_fread, a_we, a_busy, a_done, a_err} !== 5'b0 || a_csum !== 32'h0) begin
      errors++;
      $display("FAIL midload_reset: flags=%b csum=%h, required 00000 0",
               {a_fread, a_we, a_busy, a_done, a_err}, a_csum);
    end
    checks++;
    if (a_faddr !== '0 || a_waddr !== '0 || a_wdata !== '0) begin
      errors++;
      $display("FAIL midload_reset_addr: got %h/%h/%h, required 0", a_faddr, a_waddr, a_wdata);
    end
    repeat (2) @(negedge clk);
    wb = a_wr_cyc.size();
    reset_n = 1'b1;
    wait_a_done("midload_rerun");
    checks++;
    if (a_wr_cyc.size() - wb != 4 || a_csum !== ACsum) begin
      errors++;
      $display("FAIL midload_rerun: writes=%0d csum=%h, required 4 %h",
               a_wr_cyc.size() - wb, a_csum, ACsum);
    end else begin
      checks++;
      if (a_wr_addr[wb] != 0 || a_wr_data[wb] !== a_exp[0]) begin
        errors++;
        $display("FAIL midload_first: got addr %0d data %h, required addr 0 data %h",
                 a_wr_addr[wb], a_wr_data[wb], a_exp[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_waitrequest();
    test_timeout();
    test_back_to_back();
    test_gap0();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
